// File: rtl/output_link_scheduler.sv
// Output link scheduler: shares one outgoing link among five requesters
// (PE, x+, y+, x-, y-). Arbitration is round-robin per packet. Flits are paced
// by a credit counter that tracks free slots in the downstream input buffer.
//
// Handshake: a requester raises its request_din bit once a complete packet is
// buffered. grant_dout is one-hot and doubles as the requester pop: while it is
// set, the granted requester must present one flit per cycle. The grant holds
// for exactly PACKET_FLITS consecutive cycles and cannot be stalled or revoked.
// credit_din is a single-cycle pulse per slot the downstream buffer frees.
module output_link_scheduler #(
  parameter int PACKET_FLITS = 5,
  parameter int BUFFER_DEPTH = 8,
  parameter int CREDIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              request_din,
  input  logic                    credit_din,
  output logic [4:0]              grant_dout,
  output logic                    flit_valid_dout,
  output logic                    flit_last_dout,
  output logic [CREDIT_WIDTH-1:0] credit_count_dout,
  output logic                    credit_error_dout,
  output logic                    state_dout
);

  localparam int FLIT_W = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
  localparam logic [CREDIT_WIDTH-1:0] DEPTH_C  = CREDIT_WIDTH'(BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] PACKET_C = CREDIT_WIDTH'(PACKET_FLITS);
  localparam logic [CREDIT_WIDTH-1:0] CRED_ONE = CREDIT_WIDTH'(1);
  localparam logic [FLIT_W-1:0]       LAST_C   = FLIT_W'(PACKET_FLITS - 1);
  localparam logic [FLIT_W-1:0]       FLIT_ONE = FLIT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [2:0]        owner;      // index of the requester currently granted
  logic [2:0]        ptr;        // round-robin priority pointer
  logic [FLIT_W-1:0] flit_cnt;   // flits already sent in the current packet

  logic [CREDIT_WIDTH-1:0] credit_next;
  logic                    credit_overflow;
  logic [4:0]              req_eff;
  logic [2:0]              ptr_eff;
  logic [2:0]              next_ptr;
  logic                    credit_ok;
  logic                    arb_found;
  logic [2:0]              arb_win;
  logic                    arb_go;

  // Round-robin search: first set bit at or above ptr, wrapping 4 -> 0.
  // Iterating from the farthest offset down lets the nearest one win.
  function automatic logic [3:0] rr_pick(input logic [4:0] req, input logic [2:0] p);
    logic [3:0] idx;
    rr_pick = 4'b0000;
    for (int i = 4; i >= 0; i--) begin
      idx = {1'b0, p} + 4'(i);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (req[idx[2:0]]) rr_pick = {1'b1, idx[2:0]};
    end
  endfunction

  assign flit_valid_dout = |grant_dout;
  assign state_dout      = (state == BUSY);
  assign next_ptr        = (owner == 3'd4) ? 3'd0 : owner + 3'd1;

  // Credit counter next value: minus one per flit sent, plus one per credit,
  // saturating at BUFFER_DEPTH (an extra credit there is flagged as an error).
  always_comb begin
    credit_next     = credit_count_dout;
    credit_overflow = 1'b0;
    case ({flit_valid_dout, credit_din})
      2'b10:   credit_next = credit_count_dout - CRED_ONE;
      2'b01: begin
        if (credit_count_dout == DEPTH_C) credit_overflow = 1'b1;
        else                              credit_next = credit_count_dout + CRED_ONE;
      end
      default: credit_next = credit_count_dout;
    endcase
  end

  // Arbitration inputs. On the last flit of a packet the search uses the
  // advanced pointer and next-cycle credits, and masks the requester being
  // served: its request bit still reflects the packet now being popped.
  always_comb begin
    req_eff   = request_din;
    ptr_eff   = ptr;
    credit_ok = (credit_count_dout >= PACKET_C);
    if (state == BUSY) begin
      req_eff   = request_din & ~grant_dout;
      ptr_eff   = next_ptr;
      credit_ok = (credit_next >= PACKET_C);
    end
    {arb_found, arb_win} = rr_pick(req_eff, ptr_eff);
    arb_go = arb_found && credit_ok;
  end

  // Packet FSM: grant, owner, pointer, flit counter and last-flit flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      grant_dout     <= 5'b00000;
      owner          <= 3'd0;
      ptr            <= 3'd0;
      flit_cnt       <= '0;
      flit_last_dout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_go) begin
            state          <= BUSY;
            grant_dout     <= 5'(1) << arb_win;
            owner          <= arb_win;
            flit_cnt       <= '0;
            flit_last_dout <= (PACKET_FLITS == 1);
          end else begin
            grant_dout     <= 5'b00000;
            flit_last_dout <= 1'b0;
          end
        end
        BUSY: begin
          if (flit_last_dout) begin
            ptr      <= next_ptr;
            flit_cnt <= '0;
            if (arb_go) begin
              grant_dout     <= 5'(1) << arb_win;
              owner          <= arb_win;
              flit_last_dout <= (PACKET_FLITS == 1);
            end else begin
              state          <= IDLE;
              grant_dout     <= 5'b00000;
              flit_last_dout <= 1'b0;
            end
          end else begin
            flit_cnt       <= flit_cnt + FLIT_ONE;
            flit_last_dout <= ((flit_cnt + FLIT_ONE) == LAST_C);
          end
        end
        default: begin
          state      <= IDLE;
          grant_dout <= 5'b00000;
        end
      endcase
    end
  end

  // Credit counter and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_count_dout <= DEPTH_C;
      credit_error_dout <= 1'b0;
    end else begin
      credit_count_dout <= credit_next;
      if (credit_overflow) credit_error_dout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_link_scheduler.sv
// Bench for output_link_scheduler: directed scenarios, a packet-order
// scoreboard and a cycle-level credit model.
module tb_output_link_scheduler;

  localparam int PF = 5;
  localparam int BD = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [4:0]    request = 5'b00000;
  logic          credit = 1'b0;
  logic [4:0]    grant;
  logic          flit_valid;
  logic          flit_last;
  logic [CW-1:0] credit_count;
  logic          credit_error;
  logic          state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  // credit model
  int   m_cnt = BD;
  logic m_err = 1'b0;

  // packet monitor state
  logic       prev_valid = 1'b0;
  logic       prev_last  = 1'b0;
  logic [4:0] prev_grant = 5'b00000;
  int         flit_idx   = 0;

  output_link_scheduler #(
    .PACKET_FLITS(PF),
    .BUFFER_DEPTH(BD),
    .CREDIT_WIDTH(CW)
  ) dut (
    .clk              (clk),
    .reset            (rst_n),
    .request_din      (request),
    .credit_din       (credit),
    .grant_dout       (grant),
    .flit_valid_dout  (flit_valid),
    .flit_last_dout   (flit_last),
    .credit_count_dout(credit_count),
    .credit_error_dout(credit_error),
    .state_dout       (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // credit model, updated from the values present at each rising edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = BD;
      m_err = 1'b0;
    end else if (credit && !flit_valid && m_cnt == BD) begin
      m_err = 1'b1;
    end else begin
      m_cnt = m_cnt - (flit_valid ? 1 : 0) + (credit ? 1 : 0);
    end
  end

  // monitor: credit model compare, packet framing, scoreboard pop at packet start
  always @(negedge clk) begin
    if (rst_n) begin
      check("credit_count", 32'(credit_count), 32'(m_cnt));
      check("credit_error", 32'(credit_error), 32'(m_err));
      check("valid_is_or_grant", 32'(flit_valid), 32'(|grant));
      if (flit_valid) begin
        if (!prev_valid || prev_last) begin
          flit_idx = 0;
          if (exp_q.size() == 0) check("unexpected_packet", 32'(grant), 32'(0));
          else check("grant_order", 32'(grant), 32'(exp_q.pop_front()));
        end else begin
          flit_idx++;
          check("grant_held", 32'(grant), 32'(prev_grant));
        end
        check("flit_last", 32'(flit_last), 32'(flit_idx == PF - 1));
      end else begin
        check("last_when_idle", 32'(flit_last), 32'(0));
      end
      prev_valid = flit_valid;
      prev_last  = flit_last;
      prev_grant = grant;
    end else begin
      prev_valid = 1'b0;
      prev_last  = 1'b0;
      flit_idx   = 0;
    end
  end

  initial begin
    // reset
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_count", 32'(credit_count), 32'(8));
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_error", 32'(credit_error), 32'(0));
    check("rst_valid", 32'(flit_valid), 32'(0));
    check("rst_state", 32'(state_dbg), 32'(0));

    // first packet from x+
    rst_n   = 1'b1;
    request = 5'b00010;
    exp_q.push_back(5'b00010);
    tick();
    check("t1_grant", 32'(grant), 32'(5'b00010));
    check("t1_state", 32'(state_dbg), 32'(1));
    request = 5'b00000;
    repeat (4) tick();
    check("t1_last", 32'(flit_last), 32'(1));
    check("t1_grant_held", 32'(grant), 32'(5'b00010));
    tick();
    check("t1_end_grant", 32'(grant), 32'(0));
    check("t1_end_count", 32'(credit_count), 32'(3));
    check("t1_end_state", 32'(state_dbg), 32'(0));

    // credit stall: y- waits until 5 credits exist
    request = 5'b10000;
    exp_q.push_back(5'b10000);
    repeat (3) begin
      tick();
      check("stall_grant", 32'(grant), 32'(0));
    end
    credit = 1'b1;
    tick();
    tick();
    credit = 1'b0;
    check("stall_count5", 32'(credit_count), 32'(5));
    check("stall_grant_pre", 32'(grant), 32'(0));
    tick();
    check("stall_grant_go", 32'(grant), 32'(5'b10000));
    request = 5'b00000;
    repeat (5) tick();
    check("stall_end_grant", 32'(grant), 32'(0));
    check("stall_end_count", 32'(credit_count), 32'(0));

    // refill to full
    credit = 1'b1;
    repeat (8) tick();
    credit = 1'b0;
    check("refill_count", 32'(credit_count), 32'(8));
    check("refill_error", 32'(credit_error), 32'(0));

    // simultaneous credit and transfer
    request = 5'b00100;
    exp_q.push_back(5'b00100);
    tick();
    check("simul_grant", 32'(grant), 32'(5'b00100));
    request = 5'b00000;
    credit  = 1'b1;
    repeat (5) begin
      check("simul_count", 32'(credit_count), 32'(8));
      tick();
    end
    credit = 1'b0;
    check("simul_end_count", 32'(credit_count), 32'(8));
    check("simul_end_grant", 32'(grant), 32'(0));

    // overflow
    credit = 1'b1;
    tick();
    credit = 1'b0;
    check("ovf_error", 32'(credit_error), 32'(1));
    check("ovf_count", 32'(credit_count), 32'(8));
    repeat (3) tick();
    check("ovf_sticky", 32'(credit_error), 32'(1));

    // mid-packet reset on 3rd flit of a y- packet
    request = 5'b10000;
    exp_q.push_back(5'b10000);
    tick();
    check("mrst_grant", 32'(grant), 32'(5'b10000));
    request = 5'b00000;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_grant_off", 32'(grant), 32'(0));
    check("mrst_count", 32'(credit_count), 32'(8));
    check("mrst_error_clr", 32'(credit_error), 32'(0));
    check("mrst_valid", 32'(flit_valid), 32'(0));
    tick();
    tick();

    // pointer back at PE, then round-robin with all five requesting
    rst_n   = 1'b1;
    request = 5'b10001;
    exp_q.push_back(5'b00001);
    tick();
    check("rr_first_pe", 32'(grant), 32'(5'b00001));
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00100);
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b10000);
    exp_q.push_back(5'b00001);
    request = 5'b11111;
    credit  = 1'b1;
    for (int i = 0; i < 6 * PF; i++) begin
      check("rr_no_bubble", 32'(flit_valid), 32'(1));
      if (i == 6 * PF - 1) begin
        request = 5'b00000;
        credit  = 1'b0;
      end
      tick();
    end
    check("rr_done_grant", 32'(grant), 32'(0));
    check("rr_done_count", 32'(credit_count), 32'(7));
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/output_link_scheduler.md
Name: output_link_scheduler

Overview:
Per-output-port packet scheduler for the router processing element. It shares one outgoing link among five requesters (PE, x+, y+, x-, y-) using round-robin arbitration at packet granularity. It paces flits with a credit counter that mirrors free flit slots in the downstream input buffer. One instance sits in front of each output channel's crossbar mux and drives that mux's select and the flit-valid strobe.

Parameters:
PACKET_FLITS, 5, flits per packet (header + 4 data); grant held for exactly this many transfers
BUFFER_DEPTH, 8, downstream buffer depth in flits; credit counter reset value; must be >= PACKET_FLITS
CREDIT_WIDTH, 4, credit counter width; must hold BUFFER_DEPTH

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
request_din  input  5  per-requester "complete packet buffered" flag; bit0 PE, bit1 x+, bit2 y+, bit3 x-, bit4 y-
credit_din  input  1  one-cycle pulse: downstream freed one flit slot
grant_dout  output  5  one-hot crossbar select and requester pop; registered
flit_valid_dout  output  1  a flit crosses the link this cycle; equals |grant_dout
flit_last_dout  output  1  current transfer is the packet's last flit
credit_count_dout  output  CREDIT_WIDTH  free downstream slots
credit_error_dout  output  1  sticky: credit received while counter already full

Behaviour:
- Reset (async assert, sync deassert by design):
  - grant_dout=0, flit_valid_dout=0, flit_last_dout=0
  - credit_count_dout=BUFFER_DEPTH, credit_error_dout=0
  - priority pointer=0 (PE first), state IDLE, flit counter=0
- Reset asserted mid-packet aborts the packet immediately; no completion pulse.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - Arbitrate when request_din!=0 and credit_count >= PACKET_FLITS (virtual cut-through: the whole packet's credits must exist).
  - Winner is the first set bit searching from the pointer upward, wrapping 4->0.
  - Next cycle: grant_dout = one-hot winner, state BUSY, flit counter=0.
  - If the condition fails, stay IDLE; grant_dout=0.
- BUSY:
  - One flit transfers every cycle; grant is constant.
  - Flit counter increments per transfer.
  - flit_last_dout=1 when counter==PACKET_FLITS-1.
  - request_din changes during BUSY are ignored; the grant cannot be revoked.
- Last-flit cycle:
  - Pointer becomes winner+1 (mod 5).
  - Arbitration is re-evaluated in the same cycle using the updated pointer and the next-cycle credit value.
  - If it succeeds, the next packet's grant starts the following cycle (back-to-back, zero-bubble). Otherwise return to IDLE.
- Request gating on back-to-back: the requester being served is excluded from the back-to-back evaluation, because its request_din still reflects the packet being popped. It may win again only via IDLE.
- Latency: request rises in IDLE with credits available -> first flit 1 cycle later. Packet occupies exactly PACKET_FLITS consecutive cycles.
- Credit arithmetic: next = count - flit_valid + credit_din. Simultaneous transfer and credit leaves the count unchanged.
- Credit boundaries:
  - A credit arriving with count==BUFFER_DEPTH and no transfer: count saturates at BUFFER_DEPTH, credit_error_dout sets (cleared only by reset).
  - Count never underflows, since a grant implies >= PACKET_FLITS credits reserved.
- Round-robin fairness: a continuously requesting port waits at most 4 packets.

Test Plan:
- Reset: hold reset=0 -> credit_count_dout=8, grant_dout=0, credit_error_dout=0. Release with request_din=5'b00010 -> grant_dout=5'b00010 one cycle later for 5 cycles; flit_last_dout on the 5th; credit_count_dout ends at 3.
- Round-robin: all 5 request continuously, credit_din pulsed every cycle (credits stay >=5) -> grant order PE, x+, y+, x-, y-, PE, back-to-back with no idle cycle between packets.
- Credit stall: BUFFER_DEPTH=8, after one packet count=3, no credits, request_din=5'b10000 -> grant stays 0. Deliver 2 credit pulses -> count=5, grant 5'b10000 the next cycle.
- Simultaneous: credit_din=1 during every flit of a packet starting at count=8 -> count stays 8 throughout.
- Overflow: idle, count=8, one credit_din pulse -> count stays 8, credit_error_dout=1 and remains set until reset.
- Mid-packet reset: assert reset on the 3rd flit of a y- grant -> grant_dout=0 and count=8 immediately. After release the pointer is back at PE: request_din=5'b10001 -> PE is granted first.
